// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle controller: ALU op codes,
// FSM states, RISC-V opcodes (type_enums) and datapath mux encodings (defs).
package type_enums;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'd0,
    ALUOP_RTYPE  = 2'd1,
    ALUOP_ITYPE  = 2'd2,
    ALUOP_BRANCH = 2'd3
  } aluop_t;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXEC_R  = 4'd6,
    ST_EXEC_I  = 4'd7,
    ST_ALUWB   = 4'd8,
    ST_BRANCH  = 4'd9,
    ST_JAL     = 4'd10,
    ST_JALR    = 4'd11,
    ST_LUI     = 4'd12,
    ST_AUIPC   = 4'd13,
    ST_ILLEGAL = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

endpackage

package defs;

  localparam logic [1:0] MEMTOREG_ALUOUT = 2'd0;
  localparam logic [1:0] MEMTOREG_MDR    = 2'd1;
  localparam logic [1:0] MEMTOREG_PC4    = 2'd2;

  localparam logic [1:0] PCSRC_ALU      = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT   = 2'd1;
  localparam logic [1:0] PCSRC_ALU_CLR0 = 2'd2;

  localparam logic [1:0] SRCA_PC   = 2'd0;
  localparam logic [1:0] SRCA_A    = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  localparam logic [2:0] SRCB_B       = 3'd0;
  localparam logic [2:0] SRCB_FOUR    = 3'd1;
  localparam logic [2:0] SRCB_IMM     = 3'd2;
  localparam logic [2:0] SRCB_IMM_SH1 = 3'd3;
  localparam logic [2:0] SRCB_ZERO    = 3'd4;

endpackage

// File: rtl/multicycle_decode.sv
// Opcode-to-next-state map used while the controller sits in DECODE.
module multicycle_decode
  import type_enums::*;
(
  input  logic [6:0] opcode,
  output state_t     next_state
);

  // FENCE has no work in this datapath, so it retires straight back to FETCH.
  always_comb begin
    next_state = ST_ILLEGAL;
    case (opcode)
      OP_LOAD, OP_STORE: next_state = ST_MEMADR;
      OP_RTYPE:          next_state = ST_EXEC_R;
      OP_ITYPE:          next_state = ST_EXEC_I;
      OP_BRANCH:         next_state = ST_BRANCH;
      OP_JAL:            next_state = ST_JAL;
      OP_JALR:           next_state = ST_JALR;
      OP_LUI:            next_state = ST_LUI;
      OP_AUIPC:          next_state = ST_AUIPC;
      OP_FENCE:          next_state = ST_FETCH;
      default:           next_state = ST_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: sequences the shared-memory datapath and
// tracks retired instructions and illegal-opcode traps.
module multicycle_control
  import type_enums::*, defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       CTL_IorD,
  output logic       CTL_MemWrite,
  output logic       CTL_MemRead,
  output logic       CTL_IRWrite,
  output logic       CTL_RegWrite,
  output logic       CTL_PCWriteCond,
  output logic       CTL_PCWrite,
  output logic [1:0] CTL_MemToReg,
  output logic [1:0] CTL_PCSrc,
  output logic [1:0] CTL_ALUSrcA,
  output logic [2:0] CTL_ALUSrcB,
  output aluop_t     CTL_ALUOp,
  output logic       illegal,
  output logic       retire,
  output logic [31:0] instret
);

  state_t      state_q, state_d;
  state_t      decode_next;
  logic        illegal_q, illegal_d;
  logic        retire_q, retire_d;
  logic [31:0] instret_q, instret_d;

  multicycle_decode u_decode (
    .opcode     (opcode),
    .next_state (decode_next)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: state_d = decode_next;
      // IR is not rewritten after FETCH, so opcode still tells load from store.
      ST_MEMADR: state_d = (opcode == OP_STORE) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWR:  if (mem_ready) state_d = ST_FETCH;
      ST_MEMWB:  state_d = ST_FETCH;
      ST_EXEC_R, ST_EXEC_I, ST_LUI, ST_AUIPC: state_d = ST_ALUWB;
      ST_ALUWB, ST_BRANCH, ST_JAL, ST_JALR:   state_d = ST_FETCH;
      ST_ILLEGAL: state_d = ST_ILLEGAL;
      default:    state_d = ST_FETCH;
    endcase

    retire_d  = (state_d == ST_FETCH) && (state_q != ST_FETCH);
    instret_d = instret_q + {31'd0, retire_d};
    illegal_d = illegal_q | (state_d == ST_ILLEGAL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      retire_q  <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retire_q  <= retire_d;
      instret_q <= instret_d;
    end
  end

  // Strobes depend only on state_q; mem_ready gates just the FETCH writes.
  always_comb begin
    CTL_IorD        = 1'b0;
    CTL_MemWrite    = 1'b0;
    CTL_MemRead     = 1'b0;
    CTL_IRWrite     = 1'b0;
    CTL_RegWrite    = 1'b0;
    CTL_PCWriteCond = 1'b0;
    CTL_PCWrite     = 1'b0;
    CTL_MemToReg    = MEMTOREG_ALUOUT;
    CTL_PCSrc       = PCSRC_ALU;
    CTL_ALUSrcA     = SRCA_PC;
    CTL_ALUSrcB     = SRCB_B;
    CTL_ALUOp       = ALUOP_ADD;
    case (state_q)
      ST_FETCH: begin
        CTL_MemRead = 1'b1;
        CTL_ALUSrcA = SRCA_PC;
        CTL_ALUSrcB = SRCB_FOUR;
        CTL_PCSrc   = PCSRC_ALU;
        CTL_IRWrite = mem_ready;
        CTL_PCWrite = mem_ready;
      end
      ST_DECODE: begin
        CTL_ALUSrcA = SRCA_PC;
        CTL_ALUSrcB = SRCB_IMM;
      end
      ST_MEMADR: begin
        CTL_ALUSrcA = SRCA_A;
        CTL_ALUSrcB = SRCB_IMM;
      end
      ST_MEMRD: begin
        CTL_IorD    = 1'b1;
        CTL_MemRead = 1'b1;
      end
      ST_MEMWB: begin
        CTL_RegWrite = 1'b1;
        CTL_MemToReg = MEMTOREG_MDR;
      end
      ST_MEMWR: begin
        CTL_IorD     = 1'b1;
        CTL_MemWrite = 1'b1;
      end
      ST_EXEC_R: begin
        CTL_ALUSrcA = SRCA_A;
        CTL_ALUSrcB = SRCB_B;
        CTL_ALUOp   = ALUOP_RTYPE;
      end
      ST_EXEC_I: begin
        CTL_ALUSrcA = SRCA_A;
        CTL_ALUSrcB = SRCB_IMM;
        CTL_ALUOp   = ALUOP_ITYPE;
      end
      ST_ALUWB: begin
        CTL_RegWrite = 1'b1;
        CTL_MemToReg = MEMTOREG_ALUOUT;
      end
      ST_BRANCH: begin
        CTL_ALUSrcA     = SRCA_A;
        CTL_ALUSrcB     = SRCB_B;
        CTL_ALUOp       = ALUOP_BRANCH;
        CTL_PCWriteCond = 1'b1;
        CTL_PCSrc       = PCSRC_ALUOUT;
      end
      ST_JAL: begin
        CTL_PCWrite  = 1'b1;
        CTL_PCSrc    = PCSRC_ALUOUT;
        CTL_RegWrite = 1'b1;
        CTL_MemToReg = MEMTOREG_PC4;
      end
      ST_JALR: begin
        CTL_ALUSrcA  = SRCA_A;
        CTL_ALUSrcB  = SRCB_IMM;
        CTL_PCSrc    = PCSRC_ALU_CLR0;
        CTL_PCWrite  = 1'b1;
        CTL_RegWrite = 1'b1;
        CTL_MemToReg = MEMTOREG_PC4;
      end
      ST_LUI: begin
        CTL_ALUSrcA = SRCA_ZERO;
        CTL_ALUSrcB = SRCB_IMM;
      end
      ST_AUIPC: begin
        CTL_ALUSrcA = SRCA_PC;
        CTL_ALUSrcB = SRCB_IMM;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign retire  = retire_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each instruction is expanded
// into a list of expected per-cycle control vectors and replayed against the DUT.
module tb_multicycle_control;
   import type_enums::*;

   typedef struct packed {
      logic       iord;
      logic       memWrite;
      logic       memRead;
      logic       irWrite;
      logic       regWrite;
      logic       pcWriteCond;
      logic       pcWrite;
      logic [1:0] memToReg;
      logic [1:0] pcSrc;
      logic [1:0] aluSrcA;
      logic [2:0] aluSrcB;
      logic [1:0] aluOp;
      logic       illegal;
   } ctlVec_t;

   logic        clock;
   logic        reset;
   logic [6:0]  opcode;
   logic        mem_ready;
   logic        ctlIorD, ctlMemWrite, ctlMemRead, ctlIRWrite, ctlRegWrite;
   logic        ctlPCWriteCond, ctlPCWrite;
   logic [1:0]  ctlMemToReg, ctlPCSrc, ctlALUSrcA;
   logic [2:0]  ctlALUSrcB;
   aluop_t      ctlALUOp;
   logic        illegalObs;
   logic        retireObs;
   logic [31:0] instretObs;
   ctlVec_t     obsCtl;

   int          testCount = 0;
   int          failCount = 0;

   // Reference model: expected control vector per step after FETCH,
   // whether that step waits on mem_ready, and whether it never exits.
   ctlVec_t     stepCtl[$];
   bit          stepWait[$];
   bit          stepAbs[$];
   int          phase;
   bit          done;
   bit          randomReady;
   int          stallLeft;
   logic        expRetire;
   logic [31:0] expInstret;

   multicycle_control dut (
      .clk             (clock),
      .reset           (reset),
      .opcode          (opcode),
      .mem_ready       (mem_ready),
      .CTL_IorD        (ctlIorD),
      .CTL_MemWrite    (ctlMemWrite),
      .CTL_MemRead     (ctlMemRead),
      .CTL_IRWrite     (ctlIRWrite),
      .CTL_RegWrite    (ctlRegWrite),
      .CTL_PCWriteCond (ctlPCWriteCond),
      .CTL_PCWrite     (ctlPCWrite),
      .CTL_MemToReg    (ctlMemToReg),
      .CTL_PCSrc       (ctlPCSrc),
      .CTL_ALUSrcA     (ctlALUSrcA),
      .CTL_ALUSrcB     (ctlALUSrcB),
      .CTL_ALUOp       (ctlALUOp),
      .illegal         (illegalObs),
      .retire          (retireObs),
      .instret         (instretObs)
   );

   assign obsCtl = {ctlIorD, ctlMemWrite, ctlMemRead, ctlIRWrite, ctlRegWrite,
                    ctlPCWriteCond, ctlPCWrite, ctlMemToReg, ctlPCSrc,
                    ctlALUSrcA, ctlALUSrcB, ctlALUOp, illegalObs};

   // Free-running 10-unit clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Watchdog so a stuck run still ends with a visible failure.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic ctlVec_t mk(input logic [1:0] srcA, input logic [2:0] srcB);
      ctlVec_t c;
      c = '0;
      c.aluOp   = ALUOP_ADD;
      c.aluSrcA = srcA;
      c.aluSrcB = srcB;
      return c;
   endfunction

   function automatic ctlVec_t fetchCtl(input bit ready);
      ctlVec_t c;
      c = mk(2'd0, 3'd1);
      c.memRead = 1'b1;
      c.irWrite = ready;
      c.pcWrite = ready;
      return c;
   endfunction

   function automatic void addStep(input ctlVec_t c, input bit w, input bit a);
      stepCtl.push_back(c);
      stepWait.push_back(w);
      stepAbs.push_back(a);
   endfunction

   // Expand one opcode into its post-FETCH control sequence.
   function automatic void loadModel(input logic [6:0] op);
      ctlVec_t c, wb;
      stepCtl.delete();
      stepWait.delete();
      stepAbs.delete();
      phase = -1;
      done  = 1'b0;
      addStep(mk(2'd0, 3'd2), 1'b0, 1'b0);
      wb = mk(2'd0, 3'd0);
      wb.regWrite = 1'b1;
      case (op)
         7'b0000011, 7'b0100011: begin
            addStep(mk(2'd1, 3'd2), 1'b0, 1'b0);
            c = mk(2'd0, 3'd0);
            c.iord = 1'b1;
            if (op == 7'b0000011) begin
               c.memRead = 1'b1;
               addStep(c, 1'b1, 1'b0);
               c = mk(2'd0, 3'd0);
               c.regWrite = 1'b1;
               c.memToReg = 2'd1;
               addStep(c, 1'b0, 1'b0);
            end else begin
               c.memWrite = 1'b1;
               addStep(c, 1'b1, 1'b0);
            end
         end
         7'b0110011: begin
            c = mk(2'd1, 3'd0);
            c.aluOp = ALUOP_RTYPE;
            addStep(c, 1'b0, 1'b0);
            addStep(wb, 1'b0, 1'b0);
         end
         7'b0010011: begin
            c = mk(2'd1, 3'd2);
            c.aluOp = ALUOP_ITYPE;
            addStep(c, 1'b0, 1'b0);
            addStep(wb, 1'b0, 1'b0);
         end
         7'b1100011: begin
            c = mk(2'd1, 3'd0);
            c.aluOp = ALUOP_BRANCH;
            c.pcWriteCond = 1'b1;
            c.pcSrc = 2'd1;
            addStep(c, 1'b0, 1'b0);
         end
         7'b1101111: begin
            c = mk(2'd0, 3'd0);
            c.pcWrite = 1'b1;
            c.pcSrc = 2'd1;
            c.regWrite = 1'b1;
            c.memToReg = 2'd2;
            addStep(c, 1'b0, 1'b0);
         end
         7'b1100111: begin
            c = mk(2'd1, 3'd2);
            c.pcSrc = 2'd2;
            c.pcWrite = 1'b1;
            c.regWrite = 1'b1;
            c.memToReg = 2'd2;
            addStep(c, 1'b0, 1'b0);
         end
         7'b0110111: begin
            addStep(mk(2'd2, 3'd2), 1'b0, 1'b0);
            addStep(wb, 1'b0, 1'b0);
         end
         7'b0010111: begin
            addStep(mk(2'd0, 3'd2), 1'b0, 1'b0);
            addStep(wb, 1'b0, 1'b0);
         end
         7'b0001111: ;
         default: begin
            c = mk(2'd0, 3'd0);
            c.illegal = 1'b1;
            addStep(c, 1'b0, 1'b1);
         end
      endcase
   endfunction

   task automatic checkOutput(input ctlVec_t expCtl, input string tag);
      testCount++;
      assert (obsCtl === expCtl) else begin
         failCount++;
         $error("[TB] FAIL %s ctl observed=%h expected=%h", tag, obsCtl, expCtl);
      end
      testCount++;
      assert (retireObs === expRetire) else begin
         failCount++;
         $error("[TB] FAIL %s retire observed=%b expected=%b", tag, retireObs, expRetire);
      end
      testCount++;
      assert (instretObs === expInstret) else begin
         failCount++;
         $error("[TB] FAIL %s instret observed=%h expected=%h", tag, instretObs, expInstret);
      end
   endtask

   // One clock: drive mem_ready at negedge, check, then advance the model.
   task automatic applyStimulus(input string tag);
      bit ready;
      ctlVec_t expCtl;
      if (phase >= 0 && stepWait[phase] && stallLeft > 0) begin
         ready = 1'b0;
         stallLeft--;
      end else if (randomReady) begin
         ready = ($urandom_range(0, 3) != 0);
      end else begin
         ready = 1'b1;
      end
      mem_ready = ready;
      #1;
      expCtl = (phase < 0) ? fetchCtl(ready) : stepCtl[phase];
      checkOutput(expCtl, tag);
      @(posedge clock);
      expRetire = 1'b0;
      if (phase < 0) begin
         if (ready) phase = 0;
      end else if (stepAbs[phase]) begin
      end else if (stepWait[phase] && !ready) begin
      end else begin
         phase++;
         if (phase == stepCtl.size()) begin
            phase = -1;
            expRetire = 1'b1;
            expInstret = expInstret + 32'd1;
            done = 1'b1;
         end
      end
      @(negedge clock);
   endtask

   task automatic runInstr(input logic [6:0] op, input bit rnd, input int stalls, input string tag);
      int cycles;
      opcode = op;
      randomReady = rnd;
      stallLeft = stalls;
      loadModel(op);
      cycles = 0;
      while (!done && cycles < 200) begin
         applyStimulus(tag);
         cycles++;
      end
      testCount++;
      assert (done) else begin
         failCount++;
         $error("[TB] FAIL %s timeout observed=%0d cycles expected=completion", tag, cycles);
      end
   endtask

   // Idle FETCH cycle with mem_ready low, used for spot checks.
   task automatic idleCheck(input string tag);
      mem_ready = 1'b0;
      #1;
      checkOutput(fetchCtl(1'b0), tag);
      @(posedge clock);
      expRetire = 1'b0;
      @(negedge clock);
   endtask

   // Directed steps followed by a randomized instruction stream.
   initial begin
      logic [6:0] legalOps[10];
      int guard;
      legalOps = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                   7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111};
      reset = 1'b1;
      mem_ready = 1'b0;
      opcode = 7'd0;
      randomReady = 1'b0;
      stallLeft = 0;
      expRetire = 1'b0;
      expInstret = 32'd0;
      loadModel(7'b0110011);
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1;
      checkOutput(fetchCtl(1'b0), "resetState");
      @(negedge clock);
      reset = 1'b0;

      runInstr(7'b0110011, 1'b0, 0, "add");
      runInstr(7'b0000011, 1'b0, 3, "lwStall3");
      runInstr(7'b0100011, 1'b0, 0, "sw");
      runInstr(7'b1100011, 1'b0, 0, "beq");
      runInstr(7'b1100111, 1'b0, 0, "jalr");
      runInstr(7'b1101111, 1'b0, 0, "jal");
      runInstr(7'b0110111, 1'b0, 0, "lui");
      runInstr(7'b0010111, 1'b0, 0, "auipc");
      runInstr(7'b0010011, 1'b0, 0, "addi");
      runInstr(7'b0001111, 1'b0, 0, "fence");
      idleCheck("afterFence");

      for (int i = 0; i < 40; i++) begin
         runInstr(legalOps[$urandom_range(0, 9)], 1'b1, $urandom_range(0, 3), "random");
      end

      opcode = 7'b0100011;
      randomReady = 1'b0;
      stallLeft = 1000;
      loadModel(7'b0100011);
      guard = 0;
      while (phase != 2 && guard < 20) begin
         applyStimulus("toMemWr");
         guard++;
      end
      applyStimulus("memWrHold");
      mem_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      phase = -1;
      expRetire = 1'b0;
      expInstret = 32'd0;
      checkOutput(fetchCtl(1'b0), "resetMidStore");
      @(negedge clock);
      reset = 1'b0;
      stallLeft = 0;
      idleCheck("afterReset");

      mem_ready = 1'b0;
      force dut.instret_q = 32'hFFFF_FFFF;
      #1 release dut.instret_q;
      expInstret = 32'hFFFF_FFFF;
      runInstr(7'b0110011, 1'b0, 0, "wrapAdd");
      idleCheck("instretWrap");

      opcode = 7'h7F;
      randomReady = 1'b1;
      stallLeft = 0;
      loadModel(7'h7F);
      repeat (110) applyStimulus("illegal");

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
